// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file: NUM_RD combinational read ports,
// two write-back ports, a per-register busy scoreboard and a sequential clear engine.
`timescale 1ns/1ps
module gpr_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb0_en,
    input  logic [AW-1:0]            wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_en,
    input  logic [AW-1:0]            wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam bit          ZR    = (ZERO_REG != 0);
    localparam logic [AW-1:0] FIRST = ZR ? AW'(1) : '0;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q;
    logic [DATA_W-1:0] gpr [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              idle;
    logic              wb0_ok, wb1_ok;

    assign idle   = (state_q == IDLE);
    assign wb0_ok = wb0_en && !(ZR && wb0_addr == '0);
    assign wb1_ok = wb1_en && !(ZR && wb1_addr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            IDLE:  if (clr_req) state_d = CLEAR;
            CLEAR: begin
                clr_busy = 1'b1;
                if (cnt_q == LAST) begin
                    clr_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  cnt_q <= '0;
        else if (idle && clr_req)   cnt_q <= FIRST;
        else if (!idle)             cnt_q <= cnt_q + AW'(1);
    end

    // NOTE: the file is flops, not a RAM macro, so it can and must be reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) gpr[i] <= '0;
        end else if (!idle) begin
            gpr[cnt_q] <= '0;
        end else begin
            // wb1 is written last so it wins an address collision
            if (wb0_ok) gpr[wb0_addr] <= wb0_data;
            if (wb1_ok) gpr[wb1_addr] <= wb1_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (idle) begin
            if (clr_req) begin
                busy_d = '0;
            end else begin
                if (wb0_en) busy_d[wb0_addr] = 1'b0;
                if (wb1_en) busy_d[wb1_addr] = 1'b0;
                // a same-cycle issue means a newer producer is still outstanding
                if (iss_en) busy_d[iss_addr] = 1'b1;
            end
        end
        if (ZR) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = gpr[addr];
            if (idle) begin
                if (wb0_en && wb0_addr == addr) data = wb0_data;
                if (wb1_en && wb1_addr == addr) data = wb1_data;
            end
            if (ZR && addr == '0) data = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = busy_q[addr];
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench for gpr_file_mp: table-driven single-cycle vectors through
// a scoreboard queue, plus hand-written clear and reset-during-clear sequences.
`timescale 1ns/1ps
module tb_gpr_file_mp;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wb0_en, wb1_en, iss_en, clr_req;
    logic [AW-1:0]     wb0_addr, wb1_addr, iss_addr;
    logic [DW-1:0]     wb0_data, wb1_data;
    logic              clr_busy, clr_done;

    gpr_file_mp #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
        logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
        logic          ie;  logic [AW-1:0] ia;
        logic [AW-1:0] ra0; logic [AW-1:0] ra1;
        logic [DW-1:0] e0;  logic [DW-1:0] e1;  logic [1:0] eb;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                                input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                                input logic ie, input logic [AW-1:0] ia,
                                input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [1:0] eb);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie  = ie;  v.ia  = ia;  v.ra0 = ra0; v.ra1 = ra1;
        v.e0  = e0;  v.e1  = e1;  v.eb  = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [63:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [63:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: got output %0h with no expectation queued", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic idle_inputs();
        wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
        iss_en = 1'b0; iss_addr = '0; clr_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cyc, done_cyc, done_cnt, nz;
        logic done_seen;

        idle_inputs();
        rd_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_clr_busy", clr_busy, 0);
        check("reset_clr_done", clr_done, 0);
        reset = 1'b0;

        // cycle-by-cycle vectors: w0e,w0a,w0d, w1e,w1a,w1d, ie,ia, ra0,ra1, e0,e1,eb
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 5,0, 0,0,2'b00));
        vecs.push_back(mk(1,5,32'hDEADBEEF,   0,0,0,              0,0, 5,7, 32'hDEADBEEF,0,2'b00));
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 5,7, 32'hDEADBEEF,0,2'b00));
        vecs.push_back(mk(1,7,32'h11111111,   1,7,32'h22222222,   0,0, 7,5, 32'h22222222,32'hDEADBEEF,2'b00));
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 7,5, 32'h22222222,32'hDEADBEEF,2'b00));
        vecs.push_back(mk(1,0,32'hFFFFFFFF,   0,0,0,              1,0, 0,7, 0,32'h22222222,2'b00));
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 0,0, 0,0,2'b00));
        vecs.push_back(mk(0,0,0,              0,0,0,              1,3, 3,0, 0,0,2'b00));
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 3,5, 0,32'hDEADBEEF,2'b01));
        vecs.push_back(mk(0,0,0,              1,3,32'h33333333,   1,3, 3,3, 32'h33333333,32'h33333333,2'b11));
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 3,3, 32'h33333333,32'h33333333,2'b11));
        vecs.push_back(mk(1,3,32'h44444444,   0,0,0,              0,0, 3,3, 32'h44444444,32'h44444444,2'b11));
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 3,3, 32'h44444444,32'h44444444,2'b00));
        vecs.push_back(mk(1,10,32'hAAAA0000,  1,11,32'hBBBB0000,  0,0, 10,11, 32'hAAAA0000,32'hBBBB0000,2'b00));
        vecs.push_back(mk(0,0,0,              0,0,0,              0,0, 10,11, 32'hAAAA0000,32'hBBBB0000,2'b00));

        foreach (vecs[i]) begin
            @(negedge clk);
            wb0_en = vecs[i].w0e; wb0_addr = vecs[i].w0a; wb0_data = vecs[i].w0d;
            wb1_en = vecs[i].w1e; wb1_addr = vecs[i].w1a; wb1_data = vecs[i].w1d;
            iss_en = vecs[i].ie;  iss_addr = vecs[i].ia;  clr_req  = 1'b0;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            sb_push($sformatf("vec%0d_rd0", i), 64'(vecs[i].e0));
            sb_push($sformatf("vec%0d_rd1", i), 64'(vecs[i].e1));
            sb_push($sformatf("vec%0d_busy", i), 64'(vecs[i].eb));
            #1;
            sb_pop_check(64'(rd_data[31:0]));
            sb_pop_check(64'(rd_data[63:32]));
            sb_pop_check(64'(rd_busy));
        end

        // fill r1..r31 with their index; r4 marked busy on the last fill cycle
        for (int i = 1; i < DP; i++) begin
            @(negedge clk);
            idle_inputs();
            wb0_en = 1'b1; wb0_addr = 5'(i); wb0_data = 32'(i);
            if (i == DP - 1) begin iss_en = 1'b1; iss_addr = 5'd4; end
        end
        @(negedge clk);
        idle_inputs();
        clr_req = 1'b1;
        rd_addr = {5'd4, 5'd9};
        #1;
        check("fill_r9", rd_data[31:0], 9);
        check("fill_r4_busy", rd_busy[1], 1);

        busy_cyc = 0; done_cyc = 0; done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            idle_inputs();
            rd_addr = {5'd0, 5'd9};
            if (c == 5) begin wb1_en = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h99999999; end
            if (c == 20) begin
                wb0_en = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h5A5A5A5A;
                iss_en = 1'b1; iss_addr = 5'd4; clr_req = 1'b1;
            end
            #1;
            if (!clr_busy) break;
            busy_cyc++;
            if (clr_done) begin done_cnt++; done_cyc = c; end
            if (c == 5) check("clear_no_bypass_r9", rd_data[31:0], 9);
        end
        check("clear_busy_cycles", busy_cyc, DP - 1);
        check("clear_done_cycle", done_cyc, DP - 1);
        check("clear_done_count", done_cnt, 1);

        nz = 0;
        for (int a = 0; a < DP; a += 2) begin
            @(negedge clk);
            idle_inputs();
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            if (rd_data !== '0 || rd_busy !== '0) nz++;
        end
        check("clear_all_zero_not_busy", nz, 0);

        // reset while the clear engine is at cycle 10
        @(negedge clk);
        idle_inputs();
        wb0_en = 1'b1; wb0_addr = 5'd20; wb0_data = 32'h00002020;
        @(negedge clk);
        idle_inputs();
        clr_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            idle_inputs();
        end
        #1;
        check("rst_pre_clr_busy", clr_busy, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_clr_busy_low", clr_busy, 0);
        check("rst_clr_done_low", clr_done, 0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (clr_done || clr_busy) done_seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        wb0_en = 1'b1; wb0_addr = 5'd2; wb0_data = 32'h00001234;
        iss_en = 1'b1; iss_addr = 5'd8;
        rd_addr = {5'd20, 5'd2};
        sb_push("post_rst_r2_stored", 64'h1234);
        #1;
        check("rst_r20_zero", rd_data[63:32], 0);
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd8, 5'd2};
        #1;
        sb_pop_check(64'(rd_data[31:0]));
        check("post_rst_r8_busy", rd_busy[1], 1);
        check("rst_no_done_pulse", done_seen, 0);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
- Parametrised general-purpose register file for the integer pipeline, replacing the fixed 2R/1W register file.
- Provides NUM_RD combinational read ports and two write ports: WB0 (ALU) and WB1 (load).
- Adds a per-register busy scoreboard for hazard detection.
- Adds a sequential clear engine that zeroes the file one register per cycle without needing a reset.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, at least 4. Derived localparam AW = $clog2(DEPTH).
- NUM_RD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  scoreboard bit of the register addressed by each read port.
- wb0_en  in  1  write enable, port 0, active-high.
- wb0_addr  in  AW  write address, port 0.
- wb0_data  in  DATA_W  write data, port 0.
- wb1_en  in  1  write enable, port 1, active-high.
- wb1_addr  in  AW  write address, port 1.
- wb1_data  in  DATA_W  write data, port 1.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- clr_req  in  1  one-cycle request to start a sequential clear.
- clr_busy  out  1  high while the clear engine runs.
- clr_done  out  1  one-cycle pulse on the last clear cycle.

Behaviour:
- Reset (asynchronous, reset=1):
  - all registers = 0, all busy bits = 0;
  - FSM = IDLE, clr_busy = 0, clr_done = 0.
- Reads are combinational, with zero latency.
- Read bypass in IDLE: if a write enable is active and its address equals rd_addr, rd_data returns the write data in the same cycle.
  - If both write ports match, wb1_data is returned.
  - With ZERO_REG=1, address 0 is never bypassed and always reads 0.
- Writes take effect at the rising clk edge.
  - If wb0 and wb1 target the same address, wb1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Scoreboard, evaluated at each clk edge in IDLE:
  - busy[wbX_addr] is cleared for each active write port;
  - busy[iss_addr] is set when iss_en=1.
  - If issue and write hit the same address in the same cycle, set wins: the new producer is still outstanding.
  - rd_busy is combinational from the stored busy bits, not bypassed; a register written this cycle still shows busy until the edge.
  - With ZERO_REG=1, the busy bit for address 0 is tied to 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE with clr_req=1 -> CLEAR. At that edge: counter = first index (1 if ZERO_REG, else 0), all busy bits cleared.
  - CLEAR: each cycle zeroes gpr[counter] and increments counter.
  - When counter = DEPTH-1: clr_done=1 for that cycle, then return to IDLE.
  - clr_busy=1 for the whole of CLEAR: DEPTH-1 cycles with ZERO_REG=1, DEPTH cycles otherwise.
  - In CLEAR the following are ignored: wb0_en, wb1_en, iss_en and clr_req. Holding the pipeline during CLEAR is the upstream stage's responsibility.
  - In CLEAR, reads return stored contents with no bypass.
  - Counter wraps naturally at DEPTH; it is never used outside CLEAR.
- Reset asserted mid-clear: immediate return to IDLE with all registers 0; clr_done is not pulsed.
- The first cycle after the return to IDLE accepts writes and issues normally.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 via wb0 with rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF (bypass); after the edge it still reads 0xDEADBEEF with wb0_en=0.
- wb0 writes 0x11111111 and wb1 writes 0x22222222, both to r7 -> bypass and stored value are both 0x22222222.
- ZERO_REG=1: wb0 writes 0xFFFFFFFF to r0 and iss_en targets r0 -> rd_data=0 and rd_busy=0 for address 0 before and after the edge.
- iss_en on r3 -> rd_busy=1 the next cycle. Then iss_en on r3 and wb1 on r3 in the same cycle -> busy stays 1. wb0 on r3 alone -> busy=0 after the edge.
- Fill r1..r31 with the index value, pulse clr_req -> clr_busy high for 31 cycles, clr_done pulses on cycle 31, every register reads 0, all busy bits 0. A wb0 write to r9 during CLEAR is lost.
- Assert reset at clear cycle 10 -> clr_busy=0 immediately, no clr_done, all reads 0. A write to r2 on the first cycle after reset is stored.
